// File: rtl/traffic_light_seq.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_seq
// Description : RED->GREEN->YELLOW phase sequencer with OFF-state lamp blink.
//               Optional pedestrian shortening of GREEN: `define PED_REQ_EN.
// Revision    : 1.0  initial release
// ============================================================================
module traffic_light_seq #(
  parameter int TICK_DIV    = 1000,
  parameter int BLINK_TICKS = 50,
  parameter int PED_MIN     = 2
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        ctl_mod_en,
  input  logic        ctl_blink_yel,
  input  logic        ctl_blink_red,
  input  logic        ctl_profile,
  input  logic [31:0] timer_0,
  input  logic [31:0] timer_1,
`ifdef PED_REQ_EN
  input  logic        ped_req,
`endif
  output logic        lamp_red,
  output logic        lamp_yellow,
  output logic        lamp_green,
  output logic [1:0]  state,
  output logic        phase_done
);

  localparam int c_presc_w = $clog2(TICK_DIV);
  localparam int c_blink_w = $clog2(BLINK_TICKS) + 1;
  localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(TICK_DIV - 1);
  localparam logic [c_presc_w-1:0] c_presc_one = c_presc_w'(1);
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_TICKS - 1);
  localparam logic [c_blink_w-1:0] c_blink_one = c_blink_w'(1);
`ifdef PED_REQ_EN
  localparam logic [11:0] c_ped_min = 12'(PED_MIN);
`endif

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_RED    = 2'b01,
    ST_GREEN  = 2'b10,
    ST_YELLOW = 2'b11
  } state_t;

  state_t                 r_state;
  logic [c_presc_w-1:0]   r_presc;
  logic [c_blink_w-1:0]   r_blink_cnt;
  logic                   r_blink_on;
  logic [11:0]            r_cnt;
  logic                   r_lamp_red;
  logic                   r_lamp_yellow;
  logic                   r_lamp_green;
  logic                   r_phase_done;
`ifdef PED_REQ_EN
  logic                   r_ped_used;
`endif

  logic [31:0] w_timer;
  logic [11:0] w_dur_green;
  logic [11:0] w_dur_red;
  logic [11:0] w_dur_yellow;
  logic        w_tick;
  logic        w_blink_any;
  logic        w_blink_next;
  logic        w_ped_hit;

  // Durations are sampled from the live profile only at the load edge; zero means one tick.
  assign w_timer      = ctl_profile ? timer_1 : timer_0;
  assign w_dur_green  = (w_timer[31:20] == 12'd0) ? 12'd1 : w_timer[31:20];
  assign w_dur_red    = (w_timer[19:8]  == 12'd0) ? 12'd1 : w_timer[19:8];
  assign w_dur_yellow = {4'd0, (w_timer[7:0] == 8'd0) ? 8'd1 : w_timer[7:0]};

  assign w_tick       = (r_presc == c_presc_max);
  assign w_blink_any  = ctl_blink_red | ctl_blink_yel;
  assign w_blink_next = r_blink_on ^ (w_tick && (r_blink_cnt == c_blink_last));

`ifdef PED_REQ_EN
  assign w_ped_hit = (r_state == ST_GREEN) && ped_req && !r_ped_used && (r_cnt > c_ped_min);
`else
  assign w_ped_hit = 1'b0;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state       <= ST_OFF;
      r_presc       <= '0;
      r_blink_cnt   <= '0;
      r_blink_on    <= 1'b0;
      r_cnt         <= 12'd0;
      r_lamp_red    <= 1'b0;
      r_lamp_yellow <= 1'b0;
      r_lamp_green  <= 1'b0;
      r_phase_done  <= 1'b0;
`ifdef PED_REQ_EN
      r_ped_used    <= 1'b0;
`endif
    end else begin
      r_phase_done <= 1'b0;
      case (r_state)
        ST_OFF: begin
          if (ctl_mod_en) begin
            r_state       <= ST_RED;
            r_cnt         <= w_dur_red;
            r_presc       <= '0;
            r_blink_cnt   <= '0;
            r_blink_on    <= 1'b0;
            r_lamp_red    <= 1'b1;
            r_lamp_yellow <= 1'b0;
            r_lamp_green  <= 1'b0;
          end else if (w_blink_any) begin
            // Prescaler runs only to time the blink; red blink has priority over yellow.
            r_presc <= w_tick ? '0 : r_presc + c_presc_one;
            if (w_tick) begin
              r_blink_cnt <= (r_blink_cnt == c_blink_last) ? '0 : r_blink_cnt + c_blink_one;
            end
            r_blink_on    <= w_blink_next;
            r_lamp_red    <= ctl_blink_red & w_blink_next;
            r_lamp_yellow <= ~ctl_blink_red & w_blink_next;
            r_lamp_green  <= 1'b0;
          end else begin
            r_presc       <= '0;
            r_blink_cnt   <= '0;
            r_blink_on    <= 1'b0;
            r_lamp_red    <= 1'b0;
            r_lamp_yellow <= 1'b0;
            r_lamp_green  <= 1'b0;
          end
        end
        default: begin
          if (!ctl_mod_en) begin
            r_state       <= ST_OFF;
            r_cnt         <= 12'd0;
            r_presc       <= '0;
            r_lamp_red    <= 1'b0;
            r_lamp_yellow <= 1'b0;
            r_lamp_green  <= 1'b0;
`ifdef PED_REQ_EN
            r_ped_used    <= 1'b0;
`endif
          end else begin
            r_presc <= w_tick ? '0 : r_presc + c_presc_one;
            if (w_ped_hit) begin
`ifdef PED_REQ_EN
              r_cnt      <= c_ped_min;
              r_ped_used <= 1'b1;
`endif
            end else if (w_tick) begin
              if (r_cnt == 12'd1) begin
                r_phase_done <= 1'b1;
                case (r_state)
                  ST_RED: begin
                    r_state       <= ST_GREEN;
                    r_cnt         <= w_dur_green;
                    r_lamp_red    <= 1'b0;
                    r_lamp_yellow <= 1'b0;
                    r_lamp_green  <= 1'b1;
`ifdef PED_REQ_EN
                    r_ped_used    <= 1'b0;
`endif
                  end
                  ST_GREEN: begin
                    r_state       <= ST_YELLOW;
                    r_cnt         <= w_dur_yellow;
                    r_lamp_red    <= 1'b0;
                    r_lamp_yellow <= 1'b1;
                    r_lamp_green  <= 1'b0;
                  end
                  default: begin
                    r_state       <= ST_RED;
                    r_cnt         <= w_dur_red;
                    r_lamp_red    <= 1'b1;
                    r_lamp_yellow <= 1'b0;
                    r_lamp_green  <= 1'b0;
                  end
                endcase
              end else begin
                r_cnt <= r_cnt - 12'd1;
              end
            end
          end
        end
      endcase
    end
  end

  assign state       = r_state;
  assign lamp_red    = r_lamp_red;
  assign lamp_yellow = r_lamp_yellow;
  assign lamp_green  = r_lamp_green;
  assign phase_done  = r_phase_done;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_seq.sv
`default_nettype none
// Bench for traffic_light_seq: directed scenarios then random stimulus against a
// reference model that tracks remaining cycles per phase rather than ticks.
module tb_traffic_light_seq;

  localparam int TD = 4;
  localparam int BT = 2;
  localparam int PM = 2;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        ctl_mod_en;
  logic        ctl_blink_yel;
  logic        ctl_blink_red;
  logic        ctl_profile;
  logic [31:0] timer_0;
  logic [31:0] timer_1;
`ifdef PED_REQ_EN
  logic        ped_req;
`endif
  logic        lamp_red;
  logic        lamp_yellow;
  logic        lamp_green;
  logic [1:0]  state;
  logic        phase_done;

  traffic_light_seq #(
    .TICK_DIV    (TD),
    .BLINK_TICKS (BT),
    .PED_MIN     (PM)
  ) dut (
    .pclk          (pclk),
    .presetn       (presetn),
    .ctl_mod_en    (ctl_mod_en),
    .ctl_blink_yel (ctl_blink_yel),
    .ctl_blink_red (ctl_blink_red),
    .ctl_profile   (ctl_profile),
    .timer_0       (timer_0),
    .timer_1       (timer_1),
`ifdef PED_REQ_EN
    .ped_req       (ped_req),
`endif
    .lamp_red      (lamp_red),
    .lamp_yellow   (lamp_yellow),
    .lamp_green    (lamp_green),
    .state         (state),
    .phase_done    (phase_done)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase number 0..3 and cycles left in the current phase.
  int m_state;
  int m_left;
  int m_blink_cyc;
  bit m_on, m_pd, m_lr, m_ly, m_lg, m_used;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur(input logic [11:0] f);
    return (f == 12'd0) ? 1 : int'(f);
  endfunction

  task automatic model_reset();
    m_state = 0; m_left = 0; m_blink_cyc = 0;
    m_on = 0; m_pd = 0; m_lr = 0; m_ly = 0; m_lg = 0; m_used = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_step();
    logic [31:0] t;
    int partial;
    bit ped;
    t = ctl_profile ? timer_1 : timer_0;
    ped = 1'b0;
`ifdef PED_REQ_EN
    ped = ped_req;
`endif
    m_pd = 0;
    if (m_state == 0) begin
      if (ctl_mod_en) begin
        m_state = 1; m_left = dur(t[19:8]) * TD;
        m_blink_cyc = 0; m_on = 0;
      end else if (ctl_blink_red || ctl_blink_yel) begin
        m_blink_cyc++;
        if (m_blink_cyc == BT * TD) begin
          m_blink_cyc = 0;
          m_on = !m_on;
        end
      end else begin
        m_blink_cyc = 0; m_on = 0;
      end
    end else if (!ctl_mod_en) begin
      m_state = 0; m_left = 0; m_used = 0;
    end else if (m_state == 2 && ped && !m_used && ((m_left + TD - 1) / TD) > PM) begin
      m_used = 1;
      partial = ((m_left - 1) % TD) + 1;
      m_left = (PM - 1) * TD + ((partial == 1) ? TD : partial - 1);
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_pd = 1;
        case (m_state)
          1: begin m_state = 2; m_left = dur(t[31:20]) * TD; m_used = 0; end
          2: begin m_state = 3; m_left = dur({4'd0, t[7:0]}) * TD; end
          default: begin m_state = 1; m_left = dur(t[19:8]) * TD; end
        endcase
      end
    end
    if (m_state == 0) begin
      m_lr = ctl_blink_red && m_on;
      m_ly = !ctl_blink_red && ctl_blink_yel && m_on;
      m_lg = 0;
    end else begin
      m_lr = (m_state == 1); m_lg = (m_state == 2); m_ly = (m_state == 3);
    end
  endtask

  task automatic compare(input string where);
    check_val({where, " state"}, 32'(state), 32'(m_state));
    check_val({where, " lamps"}, {29'd0, lamp_red, lamp_yellow, lamp_green},
              {29'd0, m_lr, m_ly, m_lg});
    check_val({where, " phase_done"}, 32'(phase_done), 32'(m_pd));
  endtask

  function automatic logic [31:0] rnd_timer();
    return {12'($urandom_range(6)), 12'($urandom_range(4)), 8'($urandom_range(3))};
  endfunction

  task automatic randomize_inputs();
    if ($urandom_range(39) == 0) ctl_mod_en = ~ctl_mod_en;
    if ($urandom_range(29) == 0) ctl_blink_red = 1'($urandom_range(1));
    if ($urandom_range(29) == 0) ctl_blink_yel = 1'($urandom_range(1));
    if ($urandom_range(19) == 0) ctl_profile = 1'($urandom_range(1));
    if ($urandom_range(15) == 0) timer_0 = rnd_timer();
    if ($urandom_range(15) == 0) timer_1 = rnd_timer();
`ifdef PED_REQ_EN
    ped_req = ($urandom_range(7) == 0);
`endif
  endtask

  // Called right after a negedge: inputs change, model steps, then outputs compared.
  task automatic run(input int n, input bit rnd, input string tag);
    for (int i = 0; i < n; i++) begin
      if (rnd) randomize_inputs();
      model_step();
      @(negedge pclk);
      compare(tag);
    end
  endtask

  task automatic do_reset(input string tag);
    #2 presetn = 1'b0;
    #1 model_reset();
    compare({tag, " async"});
    @(negedge pclk);
    compare({tag, " held"});
    presetn = 1'b1;
  endtask

  initial begin
    presetn = 1'b0;
    ctl_mod_en = 0; ctl_blink_yel = 0; ctl_blink_red = 0; ctl_profile = 0;
    timer_0 = 32'd0; timer_1 = 32'd0;
`ifdef PED_REQ_EN
    ped_req = 0;
`endif
    model_reset();
    @(negedge pclk);
    compare("reset");
    presetn = 1'b1;
    run(2, 0, "idle");

    // RED 8, GREEN 12, YELLOW 4 cycles, then RED again.
    timer_0 = 32'h0030_0201; ctl_mod_en = 1;
    run(40, 0, "seq_p0");
    ctl_mod_en = 0;                                   // lands mid-GREEN
    run(3, 0, "disable");

    timer_1 = 32'h0010_0000; ctl_profile = 1; ctl_mod_en = 1;
    run(20, 0, "seq_p1_zero");
    ctl_mod_en = 0; ctl_profile = 0;
    run(2, 0, "disable2");

    ctl_blink_red = 1; ctl_blink_yel = 1;
    run(40, 0, "blink_red");
    ctl_blink_red = 0;
    run(20, 0, "blink_yel");
    ctl_blink_yel = 0;
    run(3, 0, "blink_off");

    ctl_mod_en = 1;
    run(21, 0, "to_yellow");
    do_reset("rst_yellow");
    run(12, 0, "restart");

`ifdef PED_REQ_EN
    ctl_mod_en = 0;
    run(2, 0, "ped_prep");
    timer_0 = 32'h00A0_0101; ctl_mod_en = 1;
    run(4 + 12, 0, "ped_green");                      // into green, third tick reached
    ped_req = 1;
    run(1, 0, "ped_req");
    ped_req = 0;
    run(3, 0, "ped_run");
    ped_req = 1;
    run(12, 0, "ped_repeat");
    ped_req = 0;
`endif

    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(599) == 0) do_reset("rnd_rst");
      else run(1, 1, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
